// File: rtl/register_bank_ex_pkg.sv
// Shared definitions for the register bank: write-operation encodings used by
// the bank, its cells and the testbench.
package register_bank_ex_pkg;

    typedef enum logic [1:0] {
        WM_LOAD = 2'b00,
        WM_INC  = 2'b01,
        WM_DEC  = 2'b10,
        WM_CLR  = 2'b11
    } wmode_e;

    localparam int unsigned MAX_BITS = 32;
    localparam int unsigned MAX_REGS = 16;

endpackage

// File: rtl/register_bank_ex_if.sv
// Control/write/read-address bundle of the register bank; the master side
// drives requests and observes Wrap, the slave side is the bank itself.
interface register_bank_ex_if
    import register_bank_ex_pkg::*;
#(
    parameter int NrOfBits = 8,
    parameter int AddrBits = 2
);
    logic                ClockEnable;
    logic                Tick;
    logic                pre;
    logic                cs;
    logic                WE;
    wmode_e              WMode;
    logic [AddrBits-1:0] WAddr;
    logic [NrOfBits-1:0] D;
    logic [AddrBits-1:0] RAddrA;
    logic [AddrBits-1:0] RAddrB;
    logic                Wrap;

    modport master (
        output ClockEnable, Tick, pre, cs, WE, WMode, WAddr, D, RAddrA, RAddrB,
        input  Wrap
    );

    modport slave (
        input  ClockEnable, Tick, pre, cs, WE, WMode, WAddr, D, RAddrA, RAddrB,
        output Wrap
    );
endinterface

// File: rtl/register_bank_ex_cell.sv
// One register of the bank: load/inc/dec/clear, preset, and a one-cycle flag
// that records whether the last enabled write wrapped around.
module register_bank_ex_cell
    import register_bank_ex_pkg::*;
#(
    parameter int NrOfBits = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pre,
    input  logic                i_en,
    input  logic                i_wr,
    input  wmode_e              i_mode,
    input  logic [NrOfBits-1:0] i_d,
    output logic [NrOfBits-1:0] o_q,
    output logic [NrOfBits-1:0] o_next,
    output logic                o_wrap
);
    localparam logic [NrOfBits-1:0] ONE = NrOfBits'(1);

    logic [NrOfBits-1:0] r_q;
    logic                r_wrap;
    logic [NrOfBits-1:0] w_next;
    logic                w_wraps;

    always_comb begin
        w_next  = r_q;
        w_wraps = 1'b0;
        case (i_mode)
            WM_LOAD: w_next = i_d;
            WM_INC: begin
                w_next  = r_q + ONE;
                w_wraps = &r_q;
            end
            WM_DEC: begin
                w_next  = r_q - ONE;
                w_wraps = ~|r_q;
            end
            WM_CLR:  w_next = '0;
            default: w_next = r_q;
        endcase
    end

    // Wrap flag follows every enabled edge so it is a single-cycle pulse,
    // and holds while the bank is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (i_pre) begin
            r_q    <= '1;
            r_wrap <= 1'b0;
        end else if (i_en) begin
            r_wrap <= i_wr & w_wraps;
            if (i_wr) begin
                r_q <= w_next;
            end
        end
    end

    assign o_q    = r_q;
    assign o_next = i_wr ? w_next : r_q;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/register_bank_ex.sv
// Multi-register bank with one write port (load/inc/dec/clr), two read ports
// (combinational or registered with optional write bypass) and tri-state outputs.
module register_bank_ex
    import register_bank_ex_pkg::*;
#(
    parameter int NrOfBits       = 8,
    parameter int NrOfRegs       = 4,
    parameter int AddrBits       = 2,
    parameter int RegisteredRead = 0,
    parameter int Bypass         = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    register_bank_ex_if.slave   bus,
    output logic [NrOfBits-1:0] QA,
    output logic [NrOfBits-1:0] QB
);
    logic                w_en;
    logic [NrOfRegs-1:0] w_wr;
    logic [NrOfRegs-1:0] w_wrap;
    logic [NrOfBits-1:0] w_cur [NrOfRegs];
    logic [NrOfBits-1:0] w_nxt [NrOfRegs];
    logic [NrOfBits-1:0] w_comb_a, w_comb_b;
    logic [NrOfBits-1:0] w_cap_a, w_cap_b;
    logic [NrOfBits-1:0] w_qa, w_qb;
    logic [NrOfBits-1:0] r_qa, r_qb;

    assign w_en = bus.ClockEnable & bus.Tick;

    // Address decode only spans existing registers, so out-of-range writes
    // select no cell and cannot raise Wrap.
    for (genvar g = 0; g < NrOfRegs; g++) begin : g_cell
        assign w_wr[g] = w_en & bus.WE & (bus.WAddr == AddrBits'(g));

        register_bank_ex_cell #(
            .NrOfBits (NrOfBits)
        ) u_cell (
            .i_clk  (Clock),
            .i_rst  (Reset),
            .i_pre  (bus.pre),
            .i_en   (w_en),
            .i_wr   (w_wr[g]),
            .i_mode (bus.WMode),
            .i_d    (bus.D),
            .o_q    (w_cur[g]),
            .o_next (w_nxt[g]),
            .o_wrap (w_wrap[g])
        );
    end

    always_comb begin
        w_comb_a = '0;
        w_comb_b = '0;
        w_cap_a  = '0;
        w_cap_b  = '0;
        for (int unsigned i = 0; i < NrOfRegs; i++) begin
            if (bus.RAddrA == AddrBits'(i)) begin
                w_comb_a = w_cur[i];
                w_cap_a  = (Bypass != 0) ? w_nxt[i] : w_cur[i];
            end
            if (bus.RAddrB == AddrBits'(i)) begin
                w_comb_b = w_cur[i];
                w_cap_b  = (Bypass != 0) ? w_nxt[i] : w_cur[i];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_qa <= '0;
            r_qb <= '0;
        end else if (bus.pre) begin
            r_qa <= '1;
            r_qb <= '1;
        end else if (w_en) begin
            r_qa <= w_cap_a;
            r_qb <= w_cap_b;
        end
    end

    assign w_qa = (RegisteredRead != 0) ? r_qa : w_comb_a;
    assign w_qb = (RegisteredRead != 0) ? r_qb : w_comb_b;

    assign QA       = bus.cs ? 'z : w_qa;
    assign QB       = bus.cs ? 'z : w_qb;
    assign bus.Wrap = |w_wrap;

endmodule

// File: tb/tb_register_bank_ex.sv
// Randomized and directed checks of four register_bank_ex configurations
// against an array-based reference model.
module tb_register_bank_ex;
    import register_bank_ex_pkg::*;

    localparam int NB = 8;
    localparam int AB = 2;
    localparam int ND = 4;

    // Per-instance configuration: register count, registered read, bypass.
    localparam int CFG_NR [ND] = '{4, 3, 4, 4};
    localparam int CFG_RR [ND] = '{0, 1, 1, 1};
    localparam int CFG_BP [ND] = '{1, 1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ce, tick, pre, cs, we;
    wmode_e        wm;
    logic [AB-1:0] waddr, ra, rb;
    logic [NB-1:0] d;

    int n_checks = 0;
    int n_errors = 0;

    register_bank_ex_if #(.NrOfBits(NB), .AddrBits(AB)) bus0 ();
    register_bank_ex_if #(.NrOfBits(NB), .AddrBits(AB)) bus1 ();
    register_bank_ex_if #(.NrOfBits(NB), .AddrBits(AB)) bus2 ();
    register_bank_ex_if #(.NrOfBits(NB), .AddrBits(AB)) bus3 ();

    wire [NB-1:0] qa0, qb0, qa1, qb1, qa2, qb2, qa3, qb3;

    // Released outputs float up so high-impedance reads as all-ones.
    assign (pull0, pull1) qa0 = '1;
    assign (pull0, pull1) qb0 = '1;
    assign (pull0, pull1) qa1 = '1;
    assign (pull0, pull1) qb1 = '1;
    assign (pull0, pull1) qa2 = '1;
    assign (pull0, pull1) qb2 = '1;
    assign (pull0, pull1) qa3 = '1;
    assign (pull0, pull1) qb3 = '1;

    register_bank_ex #(.NrOfBits(NB), .NrOfRegs(4), .AddrBits(AB), .RegisteredRead(0), .Bypass(1))
        u_dut0 (.Clock(clk), .Reset(rst), .bus(bus0.slave), .QA(qa0), .QB(qb0));
    register_bank_ex #(.NrOfBits(NB), .NrOfRegs(3), .AddrBits(AB), .RegisteredRead(1), .Bypass(1))
        u_dut1 (.Clock(clk), .Reset(rst), .bus(bus1.slave), .QA(qa1), .QB(qb1));
    register_bank_ex #(.NrOfBits(NB), .NrOfRegs(4), .AddrBits(AB), .RegisteredRead(1), .Bypass(0))
        u_dut2 (.Clock(clk), .Reset(rst), .bus(bus2.slave), .QA(qa2), .QB(qb2));
    register_bank_ex #(.NrOfBits(NB), .NrOfRegs(4), .AddrBits(AB), .RegisteredRead(1), .Bypass(1))
        u_dut3 (.Clock(clk), .Reset(rst), .bus(bus3.slave), .QA(qa3), .QB(qb3));

    int m_reg  [ND][4];
    int m_qa   [ND];
    int m_qb   [ND];
    int m_wrap [ND];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus0.ClockEnable = ce; bus0.Tick = tick; bus0.pre = pre; bus0.cs = cs; bus0.WE = we;
        bus0.WMode = wm; bus0.WAddr = waddr; bus0.D = d; bus0.RAddrA = ra; bus0.RAddrB = rb;
        bus1.ClockEnable = ce; bus1.Tick = tick; bus1.pre = pre; bus1.cs = cs; bus1.WE = we;
        bus1.WMode = wm; bus1.WAddr = waddr; bus1.D = d; bus1.RAddrA = ra; bus1.RAddrB = rb;
        bus2.ClockEnable = ce; bus2.Tick = tick; bus2.pre = pre; bus2.cs = cs; bus2.WE = we;
        bus2.WMode = wm; bus2.WAddr = waddr; bus2.D = d; bus2.RAddrA = ra; bus2.RAddrB = rb;
        bus3.ClockEnable = ce; bus3.Tick = tick; bus3.pre = pre; bus3.cs = cs; bus3.WE = we;
        bus3.WMode = wm; bus3.WAddr = waddr; bus3.D = d; bus3.RAddrA = ra; bus3.RAddrB = rb;
    endtask

    // Reference behaviour of one edge, computed from the bank's rules.
    task automatic model_step();
        int old [4];
        int wa, a, b;
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
                m_qa[k] = 0; m_qb[k] = 0; m_wrap[k] = 0;
            end else if (pre) begin
                for (int i = 0; i < 4; i++) m_reg[k][i] = 255;
                m_qa[k] = 255; m_qb[k] = 255; m_wrap[k] = 0;
            end else if (ce && tick) begin
                for (int i = 0; i < 4; i++) old[i] = m_reg[k][i];
                wa = int'(waddr);
                m_wrap[k] = 0;
                if (we && wa < CFG_NR[k]) begin
                    case (wm)
                        WM_LOAD: m_reg[k][wa] = int'(d);
                        WM_INC: begin
                            m_reg[k][wa] = (old[wa] + 1) % 256;
                            m_wrap[k] = (old[wa] == 255) ? 1 : 0;
                        end
                        WM_DEC: begin
                            m_reg[k][wa] = (old[wa] + 255) % 256;
                            m_wrap[k] = (old[wa] == 0) ? 1 : 0;
                        end
                        default: m_reg[k][wa] = 0;
                    endcase
                end
                a = int'(ra);
                b = int'(rb);
                m_qa[k] = (a < CFG_NR[k]) ? (CFG_BP[k] != 0 ? m_reg[k][a] : old[a]) : 0;
                m_qb[k] = (b < CFG_NR[k]) ? (CFG_BP[k] != 0 ? m_reg[k][b] : old[b]) : 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_q(input int k, input int latch, input logic [AB-1:0] addr);
        if (cs) return 32'hFF;
        if (CFG_RR[k] != 0) return 32'(latch);
        if (int'(addr) < CFG_NR[k]) return 32'(m_reg[k][int'(addr)]);
        return 32'h0;
    endfunction

    task automatic check_dut(input int k, input logic [NB-1:0] qa, input logic [NB-1:0] qb,
                             input logic wrap);
        check_val($sformatf("u%0d_QA", k), 32'(qa), exp_q(k, m_qa[k], ra));
        check_val($sformatf("u%0d_QB", k), 32'(qb), exp_q(k, m_qb[k], rb));
        check_val($sformatf("u%0d_Wrap", k), 32'(wrap), 32'(m_wrap[k]));
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_step();
        #1;
        check_dut(0, qa0, qb0, bus0.Wrap);
        check_dut(1, qa1, qb1, bus1.Wrap);
        check_dut(2, qa2, qb2, bus2.Wrap);
        check_dut(3, qa3, qb3, bus3.Wrap);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; tick = 1'b1; pre = 1'b0; cs = 1'b0; we = 1'b0;
        wm = WM_LOAD; waddr = '0; d = '0; ra = '0; rb = '0;
        for (int k = 0; k < ND; k++) begin
            for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
            m_qa[k] = 0; m_qb[k] = 0; m_wrap[k] = 0;
        end
        cycle();
        check_val("reset_qa0", 32'(qa0), 32'h0);
        check_val("reset_wrap0", 32'(bus0.Wrap), 32'h0);
        rst = 1'b0;

        // Load reg2 and read it combinationally; other registers stay 0.
        we = 1'b1; wm = WM_LOAD; waddr = 2'd2; d = 8'hA5; ra = 2'd2; rb = 2'd1;
        cycle();
        check_val("load_qa0", 32'(qa0), 32'hA5);
        check_val("load_qb0_other", 32'(qb0), 32'h0);

        // Increment from all-ones wraps to 0, decrement from 0 wraps to all-ones.
        waddr = 2'd1; d = 8'hFF; ra = 2'd1;
        cycle();
        wm = WM_INC;
        cycle();
        check_val("inc_wrap_val", 32'(qa0), 32'h00);
        check_val("inc_wrap_flag", 32'(bus0.Wrap), 32'h1);
        we = 1'b0;
        cycle();
        check_val("wrap_one_cycle", 32'(bus0.Wrap), 32'h0);
        we = 1'b1; wm = WM_DEC;
        cycle();
        check_val("dec_wrap_val", 32'(qa0), 32'hFF);
        check_val("dec_wrap_flag", 32'(bus0.Wrap), 32'h1);

        // Stalled edge ignores the write; preset acts even without enable.
        tick = 1'b0; wm = WM_LOAD; waddr = 2'd0; d = 8'h3C; ra = 2'd0;
        cycle();
        check_val("tick0_nochange", 32'(qa0), 32'h0);
        check_val("tick0_wrap_hold", 32'(bus0.Wrap), 32'h1);
        tick = 1'b1; we = 1'b0; pre = 1'b1; ce = 1'b0; rb = 2'd3;
        cycle();
        check_val("pre_qa0", 32'(qa0), 32'hFF);
        check_val("pre_qb2", 32'(qb2), 32'hFF);
        check_val("pre_wrap0", 32'(bus0.Wrap), 32'h0);
        pre = 1'b0; ce = 1'b1;

        // Registered read with and without write bypass.
        we = 1'b1; wm = WM_LOAD; waddr = 2'd3; d = 8'h5A; ra = 2'd3;
        cycle();
        check_val("bypass_qa3", 32'(qa3), 32'h5A);
        check_val("nobypass_qa2_old", 32'(qa2), 32'hFF);
        check_val("nr3_ignore_qa1", 32'(qa1), 32'h0);
        we = 1'b0;
        cycle();
        check_val("nobypass_qa2_new", 32'(qa2), 32'h5A);
        check_val("nr3_read3_qa1", 32'(qa1), 32'h0);

        // Reset overrides preset and a pending write.
        rst = 1'b1; pre = 1'b1; we = 1'b1; wm = WM_INC; waddr = 2'd0;
        cycle();
        check_val("rst_pre_qa0", 32'(qa0), 32'h0);
        check_val("rst_pre_wrap", 32'(bus0.Wrap), 32'h0);
        rst = 1'b0; pre = 1'b0;

        // Output disable leaves contents intact.
        wm = WM_LOAD; waddr = 2'd0; d = 8'h12; ra = 2'd0;
        cycle();
        we = 1'b0; cs = 1'b1;
        cycle();
        check_val("cs_hiz_qa0", 32'(qa0), 32'hFF);
        cs = 1'b0;
        drive();
        #1;
        check_val("cs_restore_qa0", 32'(qa0), 32'h12);

        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            pre   = ($urandom_range(0, 39) == 0);
            ce    = ($urandom_range(0, 4) != 0);
            tick  = ($urandom_range(0, 4) != 0);
            cs    = ($urandom_range(0, 9) == 0);
            we    = ($urandom_range(0, 9) < 6);
            wm    = wmode_e'($urandom_range(0, 3));
            waddr = AB'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       d = 8'hFF;
                1:       d = 8'h00;
                default: d = NB'($urandom);
            endcase
            ra = AB'($urandom_range(0, 3));
            rb = AB'($urandom_range(0, 3));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
